// File: rtl/seq_ctrl_if.sv
// Sequencer bus bundle: program-memory fetch, decoder handoff, datapath flags and status.
// master = sequencer, slave = memory/decoder/datapath side.
interface seq_ctrl_if #(
   parameter int unsigned ADDR_W = 12,
   parameter int unsigned IR_W   = 24
);
   logic              halt;
   logic [ADDR_W-1:0] pm_addr;
   logic              pm_rd;
   logic [IR_W-1:0]   pm_data;
   logic              pm_ready;
   logic [IR_W-1:0]   ir;
   logic              ir_valid;
   logic              dp_busy;
   logic              flag_z;
   logic              flag_cy;
   logic [ADDR_W-1:0] pc;
   logic              stack_err;

   modport master (
      input  halt, pm_data, pm_ready, dp_busy, flag_z, flag_cy,
      output pm_addr, pm_rd, ir, ir_valid, pc, stack_err
   );

   modport slave (
      output halt, pm_data, pm_ready, dp_busy, flag_z, flag_cy,
      input  pm_addr, pm_rd, ir, ir_valid, pc, stack_err
   );
endinterface

// File: rtl/seq_ctrl.sv
// Instruction sequencer: owns the pc, fetches over a ready handshake, issues to the decoder,
// and resolves group-0 control flow (jumps, subroutine call/return) with a return-address stack.
module seq_ctrl #(
   parameter int unsigned ADDR_W      = 12,
   parameter int unsigned IR_W        = 24,
   parameter int unsigned STACK_DEPTH = 8
) (
   input  logic       clk,
   input  logic       rst,
   seq_ctrl_if.master sq
);
   localparam int unsigned OP_W  = 7;
   localparam int unsigned GRP_W = IR_W - OP_W - ADDR_W;
   localparam int unsigned PTR_W = $clog2(STACK_DEPTH);
   localparam int unsigned CNT_W = PTR_W + 1;

   localparam logic [GRP_W-1:0] GRP0   = {1'b1, {(GRP_W-1){1'b0}}};
   localparam logic [OP_W-1:0]  OP_JMP = OP_W'(0);
   localparam logic [OP_W-1:0]  OP_JZE = OP_W'(1);
   localparam logic [OP_W-1:0]  OP_JNE = OP_W'(2);
   localparam logic [OP_W-1:0]  OP_JCY = OP_W'(3);
   localparam logic [OP_W-1:0]  OP_RET = OP_W'(4);
   localparam logic [OP_W-1:0]  OP_BSR = OP_W'(5);

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      FETCH = 2'd1,
      ISSUE = 2'd2
   } state_e;

   state_e            state_q, state_d;
   logic [ADDR_W-1:0] pc_q, pc_d;
   logic [IR_W-1:0]   ir_q, ir_d;
   logic              ir_valid_q, ir_valid_d;
   logic              pm_rd_q, pm_rd_d;
   logic              stack_err_q, stack_err_d;
   logic [CNT_W-1:0]  cnt_q, cnt_d;
   logic [ADDR_W-1:0] stk_q [STACK_DEPTH];
   logic              push_en;

   logic              accept;
   logic [ADDR_W-1:0] pc_inc;
   logic [ADDR_W-1:0] target;
   logic [OP_W-1:0]   op;
   logic              is_grp0;
   logic [PTR_W-1:0]  top_idx;
   logic              stack_full;
   logic              stack_empty;

   assign accept      = (state_q == ISSUE) && ir_valid_q && !sq.dp_busy;
   assign pc_inc      = pc_q + ADDR_W'(1);
   assign target      = ir_q[ADDR_W-1:0];
   assign op          = ir_q[ADDR_W +: OP_W];
   assign is_grp0     = (ir_q[IR_W-1 -: GRP_W] == GRP0);
   assign top_idx     = PTR_W'(cnt_q - CNT_W'(1));
   assign stack_full  = (cnt_q == CNT_W'(STACK_DEPTH));
   assign stack_empty = (cnt_q == '0);

   always_ff @(posedge clk or posedge rst) begin
      if (rst) state_q <= IDLE;
      else     state_q <= state_d;
   end

   always_comb begin
      state_d = state_q;
      case (state_q)
         IDLE:    if (!sq.halt)     state_d = FETCH;
         FETCH:   if (sq.pm_ready)  state_d = ISSUE;
         ISSUE:   if (accept)       state_d = sq.halt ? IDLE : FETCH;
         default:                   state_d = IDLE;
      endcase
   end

   // Flags are only consulted in the acceptance cycle; stack moves only on acceptance.
   always_comb begin
      pc_d        = pc_q;
      ir_d        = ir_q;
      ir_valid_d  = ir_valid_q;
      cnt_d       = cnt_q;
      stack_err_d = stack_err_q;
      push_en     = 1'b0;
      pm_rd_d     = (state_d == FETCH);
      if (state_q == FETCH && sq.pm_ready) begin
         ir_d       = sq.pm_data;
         ir_valid_d = 1'b1;
      end
      if (accept) begin
         ir_valid_d = 1'b0;
         pc_d       = pc_inc;
         if (is_grp0) begin
            case (op)
               OP_JMP: pc_d = target;
               OP_JZE: if (sq.flag_z)  pc_d = target;
               OP_JNE: if (!sq.flag_z) pc_d = target;
               OP_JCY: if (sq.flag_cy) pc_d = target;
               OP_RET: begin
                  if (stack_empty) begin
                     stack_err_d = 1'b1;
                  end else begin
                     pc_d  = stk_q[top_idx];
                     cnt_d = cnt_q - CNT_W'(1);
                  end
               end
               OP_BSR: begin
                  pc_d = target;
                  if (stack_full) begin
                     stack_err_d = 1'b1;
                  end else begin
                     push_en = 1'b1;
                     cnt_d   = cnt_q + CNT_W'(1);
                  end
               end
               default: pc_d = pc_inc;
            endcase
         end
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         pc_q        <= '0;
         ir_q        <= '0;
         ir_valid_q  <= 1'b0;
         pm_rd_q     <= 1'b0;
         stack_err_q <= 1'b0;
         cnt_q       <= '0;
      end else begin
         pc_q        <= pc_d;
         ir_q        <= ir_d;
         ir_valid_q  <= ir_valid_d;
         pm_rd_q     <= pm_rd_d;
         stack_err_q <= stack_err_d;
         cnt_q       <= cnt_d;
      end
   end

   // Stack contents are deliberately left out of reset; only the count is cleared.
   always_ff @(posedge clk) begin
      if (push_en) stk_q[cnt_q[PTR_W-1:0]] <= pc_inc;
   end

   assign sq.pm_addr   = pc_q;
   assign sq.pm_rd     = pm_rd_q;
   assign sq.ir        = ir_q;
   assign sq.ir_valid  = ir_valid_q;
   assign sq.pc        = pc_q;
   assign sq.stack_err = stack_err_q;
endmodule

// File: tb/tb_seq_ctrl.sv
// Self-checking bench for seq_ctrl: randomized memory/decoder behaviour against a
// transaction-level model (program array, pc integer, return-address queue).
module tb_seq_ctrl;
   localparam int ADDR_W = 12;
   localparam int IR_W   = 24;
   localparam int DEPTH  = 8;

   logic clk;
   logic rst;

   seq_ctrl_if #(.ADDR_W(ADDR_W), .IR_W(IR_W)) sq ();

   seq_ctrl #(.ADDR_W(ADDR_W), .IR_W(IR_W), .STACK_DEPTH(DEPTH)) dut (
      .clk (clk),
      .rst (rst),
      .sq  (sq)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   logic [23:0] pmem [4096];
   int          model_pc;
   int          stk [$];
   logic        model_err;
   int          force_z;
   int          n_checks;
   int          n_fail;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      sq.halt     = 1'b0;
      sq.pm_ready = 1'b0;
      sq.pm_data  = '0;
      sq.dp_busy  = 1'b0;
      sq.flag_z   = 1'b0;
      sq.flag_cy  = 1'b0;
      rst = 1'b1;
      tick();
      tick();
      rst = 1'b0;
      model_pc  = 0;
      stk.delete();
      model_err = 1'b0;
   endtask

   task automatic fill_plain();
      for (int i = 0; i < 4096; i++) begin
         logic [23:0] w;
         w = 24'($urandom) | 24'd1;
         if (w[23:19] == 5'b10000) w[23] = 1'b0;
         pmem[i] = w;
      end
   endtask

   // Architectural effect of accepting the instruction at model_pc with the given flags.
   function automatic void model_step(input bit z, input bit cy);
      logic [23:0] w;
      int inc, tgt, nxt;
      w   = pmem[model_pc];
      inc = (model_pc + 1) % 4096;
      tgt = int'(w[11:0]);
      nxt = inc;
      if (w[23:19] == 5'b10000) begin
         case (int'(w[18:12]))
            0: nxt = tgt;
            1: if (z)  nxt = tgt;
            2: if (!z) nxt = tgt;
            3: if (cy) nxt = tgt;
            4: begin
               if (stk.size() == 0) model_err = 1'b1;
               else nxt = stk.pop_back();
            end
            5: begin
               nxt = tgt;
               if (stk.size() == DEPTH) model_err = 1'b1;
               else stk.push_back(inc);
            end
            default: nxt = inc;
         endcase
      end
      model_pc = nxt;
   endfunction

   // Plays memory and decoder until n instructions are accepted; checks every cycle.
   task automatic run_prog(input int n, input int wmin, input int wmax,
                           input int bmin, input int bmax, input bit halt_en);
      int accepted, wait_left, busy_left, limit;
      bit exp_rd, exp_valid, nxt_rd, nxt_valid, z, cy, halt_v;
      accepted  = 0;
      wait_left = -1;
      busy_left = -1;
      exp_rd    = 1'b0;
      exp_valid = 1'b0;
      limit     = 60 * n + 200;
      for (int cyc = 0; cyc <= limit; cyc++) begin
         n_checks++;
         if (sq.pm_rd !== exp_rd) begin
            n_fail++;
            $display("FAIL pm_rd cyc=%0d got=%0b exp=%0b", cyc, sq.pm_rd, exp_rd);
         end
         if (exp_rd) begin
            n_checks++;
            if (sq.pm_addr !== 12'(model_pc)) begin
               n_fail++;
               $display("FAIL pm_addr cyc=%0d got=%03h exp=%03h", cyc, sq.pm_addr, 12'(model_pc));
            end
         end
         n_checks++;
         if (sq.ir_valid !== exp_valid) begin
            n_fail++;
            $display("FAIL ir_valid cyc=%0d got=%0b exp=%0b", cyc, sq.ir_valid, exp_valid);
         end
         if (exp_valid) begin
            n_checks++;
            if (sq.ir !== pmem[model_pc]) begin
               n_fail++;
               $display("FAIL ir cyc=%0d got=%06h exp=%06h", cyc, sq.ir, pmem[model_pc]);
            end
         end
         n_checks++;
         if (sq.pc !== 12'(model_pc)) begin
            n_fail++;
            $display("FAIL pc cyc=%0d got=%03h exp=%03h", cyc, sq.pc, 12'(model_pc));
         end
         n_checks++;
         if (sq.stack_err !== model_err) begin
            n_fail++;
            $display("FAIL stack_err cyc=%0d got=%0b exp=%0b", cyc, sq.stack_err, model_err);
         end
         if (accepted == n) break;
         if (cyc == limit) begin
            n_checks++;
            n_fail++;
            $display("FAIL run_prog timeout accepted=%0d exp=%0d", accepted, n);
            break;
         end

         halt_v     = halt_en ? ($urandom_range(3, 0) == 0) : 1'b0;
         z          = (force_z < 0) ? 1'($urandom) : 1'(force_z);
         cy         = 1'($urandom);
         sq.halt    = halt_v;
         sq.flag_z  = z;
         sq.flag_cy = cy;
         nxt_rd     = exp_rd;
         nxt_valid  = exp_valid;
         if (exp_rd) begin
            sq.dp_busy = 1'($urandom);
            if (wait_left < 0) wait_left = $urandom_range(wmax, wmin);
            if (wait_left == 0) begin
               sq.pm_ready = 1'b1;
               sq.pm_data  = pmem[model_pc];
               nxt_rd      = 1'b0;
               nxt_valid   = 1'b1;
               wait_left   = -1;
            end else begin
               sq.pm_ready = 1'b0;
               sq.pm_data  = 24'($urandom);
               wait_left--;
            end
         end else if (exp_valid) begin
            sq.pm_ready = 1'($urandom);
            sq.pm_data  = 24'($urandom);
            if (busy_left < 0) busy_left = $urandom_range(bmax, bmin);
            if (busy_left == 0) begin
               sq.dp_busy = 1'b0;
               model_step(z, cy);
               nxt_valid  = 1'b0;
               nxt_rd     = !halt_v;
               busy_left  = -1;
               accepted++;
            end else begin
               sq.dp_busy = 1'b1;
               busy_left--;
            end
         end else begin
            sq.pm_ready = 1'($urandom);
            sq.pm_data  = 24'($urandom);
            sq.dp_busy  = 1'($urandom);
            nxt_rd      = !halt_v;
         end
         exp_rd    = nxt_rd;
         exp_valid = nxt_valid;
         tick();
      end
   endtask

   task automatic test_reset();
      rst = 1'b1;
      #1;
      n_checks += 6;
      if (sq.pm_rd     !== 1'b0)   begin n_fail++; $display("FAIL reset_pm_rd got=%0b exp=0", sq.pm_rd); end
      if (sq.pm_addr   !== 12'h0)  begin n_fail++; $display("FAIL reset_pm_addr got=%03h exp=000", sq.pm_addr); end
      if (sq.ir        !== 24'h0)  begin n_fail++; $display("FAIL reset_ir got=%06h exp=000000", sq.ir); end
      if (sq.ir_valid  !== 1'b0)   begin n_fail++; $display("FAIL reset_ir_valid got=%0b exp=0", sq.ir_valid); end
      if (sq.pc        !== 12'h0)  begin n_fail++; $display("FAIL reset_pc got=%03h exp=000", sq.pc); end
      if (sq.stack_err !== 1'b0)   begin n_fail++; $display("FAIL reset_stack_err got=%0b exp=0", sq.stack_err); end
      do_reset();
      n_checks++;
      if (sq.pm_rd !== 1'b0) begin n_fail++; $display("FAIL release_cycle1 pm_rd got=%0b exp=0", sq.pm_rd); end
      tick();
      n_checks += 2;
      if (sq.pm_rd   !== 1'b1)  begin n_fail++; $display("FAIL release_cycle2 pm_rd got=%0b exp=1", sq.pm_rd); end
      if (sq.pm_addr !== 12'h0) begin n_fail++; $display("FAIL release_cycle2 pm_addr got=%03h exp=000", sq.pm_addr); end
   endtask

   task automatic test_sequential();
      do_reset();
      fill_plain();
      run_prog(8, 0, 0, 0, 0, 1'b0);
      n_checks++;
      if (sq.pm_addr !== 12'd8) begin n_fail++; $display("FAIL seq_end pm_addr got=%03h exp=008", sq.pm_addr); end
   endtask

   task automatic test_jze();
      do_reset();
      fill_plain();
      pmem[0] = 24'h801123;
      force_z = 1;
      run_prog(1, 0, 0, 0, 0, 1'b0);
      n_checks += 2;
      if (sq.pm_rd   !== 1'b1)   begin n_fail++; $display("FAIL jze_taken pm_rd got=%0b exp=1", sq.pm_rd); end
      if (sq.pm_addr !== 12'h123) begin n_fail++; $display("FAIL jze_taken pm_addr got=%03h exp=123", sq.pm_addr); end
      do_reset();
      force_z = 0;
      run_prog(1, 0, 0, 0, 0, 1'b0);
      n_checks++;
      if (sq.pm_addr !== 12'h001) begin n_fail++; $display("FAIL jze_not_taken pm_addr got=%03h exp=001", sq.pm_addr); end
      force_z = -1;
   endtask

   task automatic test_bsr_ret();
      do_reset();
      fill_plain();
      pmem[12'h000] = 24'h800010;
      pmem[12'h010] = 24'h805200;
      pmem[12'h200] = 24'h804000;
      run_prog(3, 0, 1, 0, 1, 1'b0);
      n_checks += 2;
      if (sq.pm_addr   !== 12'h011) begin n_fail++; $display("FAIL bsr_ret pm_addr got=%03h exp=011", sq.pm_addr); end
      if (sq.stack_err !== 1'b0)    begin n_fail++; $display("FAIL bsr_ret stack_err got=%0b exp=0", sq.stack_err); end
   endtask

   task automatic test_stack_overflow();
      do_reset();
      fill_plain();
      for (int k = 0; k <= 8; k++) pmem[k * 256] = {5'b10000, 7'd5, 12'((k + 1) * 256)};
      pmem[12'h900] = 24'h804000;
      for (int k = 1; k <= 7; k++) pmem[k * 256 + 1] = 24'h804000;
      pmem[12'h001] = 24'h804000;
      run_prog(19, 0, 1, 0, 1, 1'b0);
      n_checks += 2;
      if (sq.stack_err !== 1'b1)    begin n_fail++; $display("FAIL overflow stack_err got=%0b exp=1", sq.stack_err); end
      if (sq.pc        !== 12'h003) begin n_fail++; $display("FAIL overflow pc got=%03h exp=003", sq.pc); end
   endtask

   task automatic test_stall();
      do_reset();
      fill_plain();
      run_prog(4, 3, 3, 5, 5, 1'b0);
      n_checks++;
      if (sq.pc !== 12'h004) begin n_fail++; $display("FAIL stall pc got=%03h exp=004", sq.pc); end
   endtask

   task automatic test_wrap();
      do_reset();
      fill_plain();
      pmem[12'h000] = 24'h800FFF;
      run_prog(2, 0, 2, 0, 2, 1'b0);
      n_checks += 2;
      if (sq.pm_rd   !== 1'b1)    begin n_fail++; $display("FAIL wrap pm_rd got=%0b exp=1", sq.pm_rd); end
      if (sq.pm_addr !== 12'h000) begin n_fail++; $display("FAIL wrap pm_addr got=%03h exp=000", sq.pm_addr); end
   endtask

   task automatic test_reset_mid();
      do_reset();
      fill_plain();
      pmem[12'h000] = 24'h804000;
      run_prog(3, 0, 0, 0, 0, 1'b0);
      n_checks += 2;
      if (sq.pm_rd     !== 1'b1) begin n_fail++; $display("FAIL pre_rst pm_rd got=%0b exp=1", sq.pm_rd); end
      if (sq.stack_err !== 1'b1) begin n_fail++; $display("FAIL pre_rst stack_err got=%0b exp=1", sq.stack_err); end
      sq.pm_ready = 1'b1;
      sq.pm_data  = 24'h123456;
      #2;
      rst = 1'b1;
      #1;
      n_checks += 6;
      if (sq.pm_rd     !== 1'b0)  begin n_fail++; $display("FAIL async_rst pm_rd got=%0b exp=0", sq.pm_rd); end
      if (sq.pm_addr   !== 12'h0) begin n_fail++; $display("FAIL async_rst pm_addr got=%03h exp=000", sq.pm_addr); end
      if (sq.pc        !== 12'h0) begin n_fail++; $display("FAIL async_rst pc got=%03h exp=000", sq.pc); end
      if (sq.ir        !== 24'h0) begin n_fail++; $display("FAIL async_rst ir got=%06h exp=000000", sq.ir); end
      if (sq.ir_valid  !== 1'b0)  begin n_fail++; $display("FAIL async_rst ir_valid got=%0b exp=0", sq.ir_valid); end
      if (sq.stack_err !== 1'b0)  begin n_fail++; $display("FAIL async_rst stack_err got=%0b exp=0", sq.stack_err); end
      tick();
      n_checks++;
      if (sq.ir_valid !== 1'b0) begin n_fail++; $display("FAIL rst_discard ir_valid got=%0b exp=0", sq.ir_valid); end
      rst         = 1'b0;
      sq.pm_ready = 1'b0;
      model_pc    = 0;
      stk.delete();
      model_err   = 1'b0;
      run_prog(2, 0, 1, 0, 1, 1'b0);
   endtask

   task automatic test_random();
      do_reset();
      for (int i = 0; i < 4096; i++) begin
         logic [23:0] w;
         w = 24'($urandom);
         if ($urandom_range(1, 0) == 1) w[23:12] = {5'b10000, 7'($urandom_range(7, 0))};
         pmem[i] = w;
      end
      run_prog(300, 0, 3, 0, 3, 1'b1);
   endtask

   initial begin
      #1000000;
      $display("FAIL watchdog expired");
      $fatal(1);
   end

   initial begin
      n_checks = 0;
      n_fail   = 0;
      force_z  = -1;
      rst      = 1'b0;
      sq.halt = 1'b0; sq.pm_ready = 1'b0; sq.pm_data = '0;
      sq.dp_busy = 1'b0; sq.flag_z = 1'b0; sq.flag_cy = 1'b0;
      tick();
      test_reset();
      test_sequential();
      test_jze();
      test_bsr_ret();
      test_stack_overflow();
      test_stall();
      test_wrap();
      test_reset_mid();
      test_random();
      $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
      $finish;
   end
endmodule
